// File: rtl/memory_pkg.sv
// Shared types for the pair-matching board: cell states, controller states and
// cursor direction codes.
package memory_pkg;

    typedef enum logic [1:0] {
        HIDDEN  = 2'd0,
        SHOWN   = 2'd1,
        MATCHED = 2'd2
    } cell_state_t;

    typedef enum logic [2:0] {
        PICK1,
        PICK2,
        CHECK,
        HOLD,
        OVER
    } board_fsm_t;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    // Counter width that still works for a single-entry range.
    function automatic int unsigned min_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/memory_board_cell.sv
// One board cell: a two-bit state register driven by the board controller.
module board_cell
    import memory_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        set_shown,
    input  logic        set_matched,
    input  logic        set_hidden,
    output cell_state_t state
);

    // NOTE: state registers use non-blocking assignments so every cell samples
    // the same pre-edge controls regardless of evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             state <= HIDDEN;
        else if (clear)       state <= HIDDEN;
        else if (set_matched) state <= MATCHED;
        else if (set_hidden)  state <= HIDDEN;
        else if (set_shown)   state <= SHOWN;
    end

endmodule

// File: rtl/memory_board.sv
// Board controller for the pair-matching game: cursor, two-pick sequencing,
// label compare, mismatch hide delay, turn alternation, scoring, end of game.
module memory_board
    import memory_pkg::*;
#(
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int LABEL_W     = 4,
    parameter int HIDE_CYCLES = 25000000,
    parameter int SCORE_W     = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            restart,
    input  logic                            move_valid,
    input  logic [1:0]                      move_dir,
    input  logic                            select,
    input  logic [ROWS*COLS*LABEL_W-1:0]    labels,
    output logic [2*ROWS*COLS-1:0]          cell_state,
    output logic [$clog2(ROWS*COLS)-1:0]    cursor_idx,
    output logic                            player,
    output logic [SCORE_W-1:0]              score0,
    output logic [SCORE_W-1:0]              score1,
    output logic                            busy,
    output logic                            game_over
);

    localparam int N     = ROWS * COLS;
    localparam int IDX_W = $clog2(N);
    localparam int RW    = min_width(ROWS);
    localparam int CW    = min_width(COLS);
    localparam int TW    = min_width(HIDE_CYCLES);
    localparam int CNT_W = $clog2(N + 1);

    if ((N % 2) != 0) begin : g_odd_board
        $error("memory_board: ROWS*COLS must be even");
    end

    board_fsm_t         state;
    cell_state_t        cells [N];
    logic [IDX_W-1:0]   idx1, idx2;
    logic [TW-1:0]      timer;
    logic [CNT_W-1:0]   matched_cnt;
    logic [RW-1:0]      row, row_next;
    logic [CW-1:0]      col, col_next;
    logic               picking, pick, labels_eq, do_match, do_hide;

    assign picking   = (state == PICK1) || (state == PICK2);
    assign pick      = picking && select && (cells[cursor_idx] == HIDDEN);
    assign labels_eq = labels[int'(idx1)*LABEL_W +: LABEL_W] ==
                       labels[int'(idx2)*LABEL_W +: LABEL_W];
    assign do_match  = (state == CHECK) && labels_eq;
    assign do_hide   = (state == HOLD) && (timer == '0);

    for (genvar i = 0; i < N; i++) begin : g_cell
        board_cell u_cell (
            .clk         (clk),
            .rst         (rst),
            .clear       (restart),
            .set_shown   (pick && (cursor_idx == IDX_W'(i))),
            .set_matched (do_match && ((idx1 == IDX_W'(i)) || (idx2 == IDX_W'(i)))),
            .set_hidden  (do_hide && ((idx1 == IDX_W'(i)) || (idx2 == IDX_W'(i)))),
            .state       (cells[i])
        );
        assign cell_state[2*i +: 2] = cells[i];
    end

    // Moves wrap within the current row or column and are frozen outside the pick states.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        row_next = row;
        col_next = col;
        if (picking && move_valid) begin
            case (move_dir)
                DIR_UP:    row_next = (row == '0) ? RW'(ROWS - 1) : row - 1'b1;
                DIR_DOWN:  row_next = (row == RW'(ROWS - 1)) ? '0 : row + 1'b1;
                DIR_LEFT:  col_next = (col == '0) ? CW'(COLS - 1) : col - 1'b1;
                default:   col_next = (col == CW'(COLS - 1)) ? '0 : col + 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row        <= '0;
            col        <= '0;
            cursor_idx <= '0;
        end else if (restart) begin
            row        <= '0;
            col        <= '0;
            cursor_idx <= '0;
        end else begin
            row        <= row_next;
            col        <= col_next;
            cursor_idx <= IDX_W'(int'(row_next) * COLS + int'(col_next));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst || restart) begin
            state       <= PICK1;
            idx1        <= '0;
            idx2        <= '0;
            timer       <= '0;
            matched_cnt <= '0;
            player      <= 1'b0;
            score0      <= '0;
            score1      <= '0;
            busy        <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            case (state)
                PICK1: if (pick) begin
                    idx1  <= cursor_idx;
                    state <= PICK2;
                end
                PICK2: if (pick) begin
                    idx2  <= cursor_idx;
                    state <= CHECK;
                    busy  <= 1'b1;
                end
                CHECK: if (labels_eq) begin
                    if (!player && score0 != '1) score0 <= score0 + 1'b1;
                    if (player && score1 != '1)  score1 <= score1 + 1'b1;
                    matched_cnt <= matched_cnt + CNT_W'(2);
                    busy        <= 1'b0;
                    if (int'(matched_cnt) + 2 == N) begin
                        state     <= OVER;
                        game_over <= 1'b1;
                    end else begin
                        state <= PICK1;
                    end
                end else begin
                    timer <= TW'(HIDE_CYCLES - 1);
                    state <= HOLD;
                end
                HOLD: if (timer == '0) begin
                    player <= ~player;
                    busy   <= 1'b0;
                    state  <= PICK1;
                end else begin
                    timer <= timer - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_board.sv
// Directed self-checking bench for memory_board on a 2x2 board with labels 3,1,3,1.
module tb_memory_board;
    import memory_pkg::*;

    logic        clk;
    logic        rst;
    logic        restart;
    logic        move_valid;
    logic [1:0]  move_dir;
    logic        select;
    logic [15:0] labels;
    logic [7:0]  cell_state;
    logic [1:0]  cursor_idx;
    logic        player;
    logic [3:0]  score0;
    logic [3:0]  score1;
    logic        busy;
    logic        game_over;

    int n_cmp = 0;
    int n_err = 0;
    int busy_cycles;

    memory_board #(
        .ROWS        (2),
        .COLS        (2),
        .LABEL_W     (4),
        .HIDE_CYCLES (4),
        .SCORE_W     (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .restart    (restart),
        .move_valid (move_valid),
        .move_dir   (move_dir),
        .select     (select),
        .labels     (labels),
        .cell_state (cell_state),
        .cursor_idx (cursor_idx),
        .player     (player),
        .score0     (score0),
        .score1     (score1),
        .busy       (busy),
        .game_over  (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_move(input logic [1:0] dir);
        move_valid = 1'b1;
        move_dir   = dir;
        tick();
        move_valid = 1'b0;
    endtask

    task automatic do_select();
        select = 1'b1;
        tick();
        select = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_cells"},  32'(cell_state), 32'h00);
        check({tag, "_cursor"}, 32'(cursor_idx), 32'd0);
        check({tag, "_player"}, 32'(player),     32'd0);
        check({tag, "_score0"}, 32'(score0),     32'd0);
        check({tag, "_score1"}, 32'(score1),     32'd0);
        check({tag, "_busy"},   32'(busy),       32'd0);
        check({tag, "_over"},   32'(game_over),  32'd0);
    endtask

    initial begin
        rst        = 1'b0;
        restart    = 1'b0;
        move_valid = 1'b0;
        move_dir   = DIR_UP;
        select     = 1'b0;
        labels     = 16'h1313;
        tick();
        tick();
        rst = 1'b1;
        tick();

        // 1. reset state
        check_idle("reset");

        // 2. cursor wrap on both axes
        do_move(DIR_LEFT);
        check("wrap_left", 32'(cursor_idx), 32'd1);
        do_move(DIR_UP);
        check("wrap_up", 32'(cursor_idx), 32'd3);
        do_move(DIR_DOWN);
        check("wrap_down", 32'(cursor_idx), 32'd1);
        do_move(DIR_LEFT);
        check("left_to_0", 32'(cursor_idx), 32'd0);

        // 3. matching pair 0/2
        do_select();
        check("m_pick1_cells", 32'(cell_state), 32'h01);
        do_move(DIR_DOWN);
        check("m_cursor2", 32'(cursor_idx), 32'd2);
        do_select();
        check("m_check_busy", 32'(busy), 32'd1);
        check("m_check_cells", 32'(cell_state), 32'h11);
        tick();
        check("m_busy_drop", 32'(busy), 32'd0);
        check("m_cells", 32'(cell_state), 32'h22);
        check("m_score0", 32'(score0), 32'd1);
        check("m_player", 32'(player), 32'd0);

        // 4. mismatch 0/1 with a dropped select+move during HOLD
        do_reset();
        do_select();
        do_move(DIR_RIGHT);
        do_select();
        busy_cycles = 0;
        for (int k = 0; k < 20; k++) begin
            if (!busy) break;
            busy_cycles++;
            if (k == 2) begin
                select     = 1'b1;
                move_valid = 1'b1;
                move_dir   = DIR_RIGHT;
            end
            tick();
            select     = 1'b0;
            move_valid = 1'b0;
            if (k == 2) begin
                check("hold_sel_cells", 32'(cell_state), 32'h05);
                check("hold_move_cursor", 32'(cursor_idx), 32'd1);
            end
        end
        check("mm_busy_cycles", 32'(busy_cycles), 32'd5);
        check("mm_cells", 32'(cell_state), 32'h00);
        check("mm_player", 32'(player), 32'd1);
        check("mm_score0", 32'(score0), 32'd0);

        // 5. full game by player 0, then frozen, then restart
        do_reset();
        do_select();
        do_move(DIR_DOWN);
        do_select();
        tick();
        check("g_pair1_cells", 32'(cell_state), 32'h22);
        do_move(DIR_UP);
        do_move(DIR_RIGHT);
        check("g_cursor1", 32'(cursor_idx), 32'd1);
        select     = 1'b1;
        move_valid = 1'b1;
        move_dir   = DIR_DOWN;
        tick();
        select     = 1'b0;
        move_valid = 1'b0;
        check("g_selmove_cells", 32'(cell_state), 32'h26);
        check("g_selmove_cursor", 32'(cursor_idx), 32'd3);
        do_select();
        tick();
        check("g_over", 32'(game_over), 32'd1);
        check("g_score0", 32'(score0), 32'd2);
        check("g_cells", 32'(cell_state), 32'hAA);
        check("g_player", 32'(player), 32'd0);
        select     = 1'b1;
        move_valid = 1'b1;
        move_dir   = DIR_LEFT;
        tick();
        select     = 1'b0;
        move_valid = 1'b0;
        tick();
        check("frz_cursor", 32'(cursor_idx), 32'd3);
        check("frz_cells", 32'(cell_state), 32'hAA);
        check("frz_over", 32'(game_over), 32'd1);
        check("frz_score0", 32'(score0), 32'd2);
        check("frz_busy", 32'(busy), 32'd0);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check_idle("restart");

        // 6. asynchronous reset during the third HOLD cycle
        do_select();
        do_move(DIR_RIGHT);
        do_select();
        tick();
        tick();
        tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_cells", 32'(cell_state), 32'h00);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_player", 32'(player), 32'd0);
        check("arst_cursor", 32'(cursor_idx), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        do_move(DIR_DOWN);
        do_select();
        check("post_rst_cells", 32'(cell_state), 32'h10);
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
